// File: rtl/escalonador_display.sv
// Digit scan and display-source scheduler for the 4-digit multiplexed 7-seg display.
// Drives the digit index, blanked active-low anodes and the drink/sensor source select.
module escalonador_display #(
    parameter int unsigned DIV_SCAN     = 50000,
    parameter int unsigned BLANK_CYC    = 500,
    parameter int unsigned HOLD_FRAMES  = 250,
    parameter int unsigned ALERT_FRAMES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       modo_auto,
    input  logic       entrada,
    input  logic       req_sensor,
    output logic [1:0] dig_sel,
    output logic [3:0] anodo_n,
    output logic       sel_fonte,
    output logic       alerta_ativo,
    output logic       frame_tick
);

    localparam int unsigned PW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
    localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int unsigned AW = (ALERT_FRAMES > 1) ? $clog2(ALERT_FRAMES) : 1;

    localparam logic [1:0] ST_BEBIDA = 2'd0;
    localparam logic [1:0] ST_SENSOR = 2'd1;
    localparam logic [1:0] ST_ALERTA = 2'd2;

    logic [PW-1:0] presc, presc_nx;
    logic [1:0]    dig_nx;
    logic          slot_end;
    logic          frame_end;
    logic [3:0]    anodo_nx;
    logic [1:0]    state, state_nx;
    logic [HW-1:0] hold, hold_nx;
    logic [AW-1:0] alert, alert_nx;
    logic          pend, pend_nx;

    // Prescaler and digit counter; anodes derived from the values they will hold
    always_comb begin
        presc_nx  = presc;
        dig_nx    = dig_sel;
        slot_end  = (presc == PW'(DIV_SCAN - 1));
        frame_end = en & slot_end & (dig_sel == 2'd3);
        if (en) begin
            if (slot_end) begin
                presc_nx = '0;
                dig_nx   = dig_sel + 2'd1;
            end else begin
                presc_nx = presc + PW'(1);
            end
        end
        if (!en || ((32'(presc_nx) + 32'd1) <= BLANK_CYC)) begin
            anodo_nx = 4'b1111;
        end else begin
            anodo_nx = ~(4'b0001 << dig_nx);
        end
    end

    // Source FSM: decisions only at frame boundaries, pending alert has top priority
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        alert_nx = alert;
        pend_nx  = pend | req_sensor;
        if (frame_end) begin
            if (pend) begin
                state_nx = ST_ALERTA;
                pend_nx  = 1'b0;
            end else begin
                case (state)
                    ST_BEBIDA: begin
                        if (modo_auto && (hold == HW'(HOLD_FRAMES - 1))) state_nx = ST_SENSOR;
                        else if (!modo_auto && entrada)                state_nx = ST_SENSOR;
                        else if (modo_auto)                            hold_nx  = hold + HW'(1);
                        else                                           hold_nx  = '0;
                    end
                    ST_SENSOR: begin
                        if (modo_auto && (hold == HW'(HOLD_FRAMES - 1))) state_nx = ST_BEBIDA;
                        else if (!modo_auto && !entrada)               state_nx = ST_BEBIDA;
                        else if (modo_auto)                            hold_nx  = hold + HW'(1);
                        else                                           hold_nx  = '0;
                    end
                    ST_ALERTA: begin
                        if (alert == AW'(ALERT_FRAMES - 1)) begin
                            state_nx = (!modo_auto && entrada) ? ST_SENSOR : ST_BEBIDA;
                        end else begin
                            alert_nx = alert + AW'(1);
                        end
                    end
                    default: state_nx = ST_BEBIDA;
                endcase
            end
            if ((state_nx != state) || pend) begin
                hold_nx  = '0;
                alert_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            dig_sel      <= 2'd0;
            anodo_n      <= 4'b1111;
            frame_tick   <= 1'b0;
            state        <= ST_BEBIDA;
            hold         <= '0;
            alert        <= '0;
            pend         <= 1'b0;
            sel_fonte    <= 1'b0;
            alerta_ativo <= 1'b0;
        end else begin
            presc        <= presc_nx;
            dig_sel      <= dig_nx;
            anodo_n      <= anodo_nx;
            frame_tick   <= frame_end;
            state        <= state_nx;
            hold         <= hold_nx;
            alert        <= alert_nx;
            pend         <= pend_nx;
            sel_fonte    <= (state_nx != ST_BEBIDA);
            alerta_ativo <= (state_nx == ST_ALERTA);
        end
    end

endmodule

// File: tb/tb_escalonador_display.sv
// Bench for escalonador_display: directed scenarios plus random traffic against a frame-level model.
// Two instances share inputs, one with blanking and one without.
module tb_escalonador_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int HOLD  = 3;
    localparam int ALRT  = 2;
    localparam int SLOTS = DIV * 4;

    logic clk = 1'b0;
    logic rst_n, en, modo_auto, entrada, req_sensor;
    logic [1:0] a_dig, b_dig;
    logic [3:0] a_an, b_an;
    logic a_sel, b_sel, a_alr, b_alr, a_tick, b_tick;

    int n_checks = 0;
    int n_errors = 0;
    int kcnt = 0;

    // Model: scan position within the frame, shown source (0 drink, 1 sensor, 2 alert)
    int m_scan = 0;
    int m_src = 0;
    int m_frames = 0;
    int m_pend = 0;
    int m_tick = 0;
    int m_en = 0;

    escalonador_display #(.DIV_SCAN(DIV), .BLANK_CYC(BLANK), .HOLD_FRAMES(HOLD), .ALERT_FRAMES(ALRT)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .modo_auto(modo_auto), .entrada(entrada),
        .req_sensor(req_sensor), .dig_sel(a_dig), .anodo_n(a_an), .sel_fonte(a_sel),
        .alerta_ativo(a_alr), .frame_tick(a_tick));

    escalonador_display #(.DIV_SCAN(DIV), .BLANK_CYC(0), .HOLD_FRAMES(HOLD), .ALERT_FRAMES(ALRT)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .modo_auto(modo_auto), .entrada(entrada),
        .req_sensor(req_sensor), .dig_sel(b_dig), .anodo_n(b_an), .sel_fonte(b_sel),
        .alerta_ativo(b_alr), .frame_tick(b_tick));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", nm, $time, kcnt, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int blank);
        logic [3:0] one;
        one = 4'b0001;
        if (m_en == 0 || (m_scan % DIV) < blank) return 4'b1111;
        return ~(one << (m_scan / DIV));
    endfunction

    // Frame-level reference model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan = 0; m_src = 0; m_frames = 0; m_pend = 0; m_tick = 0; m_en = 0;
        end else begin
            int fe, old_pend;
            fe = (en && m_scan == SLOTS - 1) ? 1 : 0;
            old_pend = m_pend;
            m_pend = (fe != 0 && old_pend != 0) ? 0 : (old_pend | int'(req_sensor));
            if (fe != 0) begin
                if (old_pend != 0) begin
                    m_src = 2; m_frames = 0;
                end else if (m_src == 2) begin
                    m_frames++;
                    if (m_frames == ALRT) begin
                        m_src = modo_auto ? 0 : (entrada ? 1 : 0);
                        m_frames = 0;
                    end
                end else if (modo_auto) begin
                    m_frames++;
                    if (m_frames == HOLD) begin
                        m_src = 1 - m_src;
                        m_frames = 0;
                    end
                end else begin
                    m_src = entrada ? 1 : 0;
                    m_frames = 0;
                end
            end
            m_tick = fe;
            m_en = int'(en);
            if (en) m_scan = (m_scan + 1) % SLOTS;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("dig_a",   32'(a_dig),  32'(m_scan / DIV));
            check("dig_b",   32'(b_dig),  32'(m_scan / DIV));
            check("anodo_a", 32'(a_an),   32'(exp_an(BLANK)));
            check("anodo_b", 32'(b_an),   32'(exp_an(0)));
            check("sel_a",   32'(a_sel),  32'(m_src != 0));
            check("sel_b",   32'(b_sel),  32'(m_src != 0));
            check("alr_a",   32'(a_alr),  32'(m_src == 2));
            check("tick_a",  32'(a_tick), 32'(m_tick));
            check("tick_b",  32'(b_tick), 32'(m_tick));
        end
    end

    task automatic go_to(input int k);
        while (kcnt < k) begin
            @(negedge clk);
            kcnt++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dig"},   32'(a_dig), 32'd0);
        check({tag, "_an_a"},  32'(a_an),  32'hF);
        check({tag, "_an_b"},  32'(b_an),  32'hF);
        check({tag, "_sel"},   32'(a_sel), 32'd0);
        check({tag, "_alr"},   32'(a_alr), 32'd0);
        check({tag, "_tick"},  32'(a_tick), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; modo_auto = 1'b1; entrada = 1'b0; req_sensor = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        #1 rst_n = 1'b1; en = 1'b1;
        kcnt = 0;

        go_to(1);   check("k1_an_a", 32'(a_an), 32'hF); check("k1_an_b", 32'(b_an), 32'hE);
        go_to(2);   check("k2_an_a", 32'(a_an), 32'hE);
        go_to(10);  check("k10_an_a", 32'(a_an), 32'hD); check("k10_dig", 32'(a_dig), 32'd1);
        go_to(32);  check("k32_tick", 32'(a_tick), 32'd1); check("k32_dig", 32'(a_dig), 32'd0);
        go_to(33);  check("k33_tick", 32'(a_tick), 32'd0);
        go_to(95);  check("k95_sel", 32'(a_sel), 32'd0);
        go_to(96);  check("k96_sel", 32'(a_sel), 32'd1);

        go_to(100); #1 req_sensor = 1'b1;
        go_to(101); #1 req_sensor = 1'b0;
        go_to(127); check("k127_alr", 32'(a_alr), 32'd0);
        go_to(128); check("k128_alr", 32'(a_alr), 32'd1); check("k128_sel", 32'(a_sel), 32'd1);
        go_to(191); check("k191_alr", 32'(a_alr), 32'd1);
        go_to(192); check("k192_alr", 32'(a_alr), 32'd0); check("k192_sel", 32'(a_sel), 32'd0);

        // Freeze mid-slot with an alert request arriving while frozen
        go_to(203); check("k203_an", 32'(a_an), 32'hD);
        #1 en = 1'b0; req_sensor = 1'b1;
        go_to(204); check("k204_an", 32'(a_an), 32'hF); check("k204_dig", 32'(a_dig), 32'd1);
        #1 req_sensor = 1'b0;
        go_to(223); check("k223_an", 32'(a_an), 32'hF); check("k223_dig", 32'(a_dig), 32'd1);
        #1 en = 1'b1;
        go_to(224); check("k224_an", 32'(a_an), 32'hD);
        go_to(243); check("k243_alr", 32'(a_alr), 32'd0);
        go_to(244); check("k244_alr", 32'(a_alr), 32'd1);

        // Manual mode: entrada raised mid-frame only acts at the next boundary
        go_to(250); #1 modo_auto = 1'b0; entrada = 1'b0;
        go_to(308); check("k308_sel", 32'(a_sel), 32'd0); check("k308_alr", 32'(a_alr), 32'd0);
        go_to(320); #1 entrada = 1'b1;
        go_to(339); check("k339_sel", 32'(a_sel), 32'd0);
        go_to(340); check("k340_sel", 32'(a_sel), 32'd1);
        #1 req_sensor = 1'b1;
        go_to(341); #1 req_sensor = 1'b0;
        go_to(380); check("k380_alr", 32'(a_alr), 32'd1);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        go_to(381); #1 rst_n = 1'b1; modo_auto = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            req_sensor = 1'b0;
            rst_n = 1'b1;
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                #1 check_reset_vals("rst_rnd");
            end else begin
                en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 299) == 0) modo_auto = ~modo_auto;
                if ($urandom_range(0, 49) == 0) entrada = ~entrada;
                req_sensor = ($urandom_range(0, 149) == 0);
            end
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
